// File: rtl/seg7_scan_ctrl.sv
// Multiplexed 7-segment scan controller: one digit per slot with a blanking guard,
// leading-zero suppression, and tear-free frame-boundary loads.
module seg7_scan_ctrl #(
    parameter int NUM_DIGITS  = 4,
    parameter int REFRESH_DIV = 100000,
    parameter int GUARD       = 1000,
    parameter bit BLANK_LZ    = 1'b1,
    localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    load,
    input  logic [4*NUM_DIGITS-1:0] value_in,
    output logic [3:0]              bcd_out,
    output logic                    dec_en,
    output logic [NUM_DIGITS-1:0]   an,
    output logic [IW-1:0]           digit_idx,
    output logic                    load_ack,
    output logic                    err
);
    localparam int CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(REFRESH_DIV - 1);
    localparam logic [CW-1:0] GUARD_C = CW'(GUARD);
    localparam logic [IW-1:0] IDX_MAX = IW'(NUM_DIGITS - 1);

    typedef enum logic {BLANK, DRIVE} state_t;

    state_t                           state, state_nxt;
    logic [CW-1:0]                    cnt, cnt_nxt;
    logic [IW-1:0]                    idx_nxt;
    logic [NUM_DIGITS-1:0][3:0]       disp, disp_nxt, shadow, shadow_nxt;
    logic                             pending, pending_nxt;
    logic                             ack_nxt, err_nxt, en_nxt, slot_end, frame_end, lz;
    logic [3:0]                       bcd_nxt;
    logic [NUM_DIGITS-1:0]            an_nxt, hi_zero;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= BLANK;
            cnt       <= '0;
            digit_idx <= '0;
            disp      <= '0;
            shadow    <= '0;
            pending   <= 1'b0;
            an        <= '1;
            dec_en    <= 1'b0;
            bcd_out   <= 4'd0;
            load_ack  <= 1'b0;
            err       <= 1'b0;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            digit_idx <= idx_nxt;
            disp      <= disp_nxt;
            shadow    <= shadow_nxt;
            pending   <= pending_nxt;
            an        <= an_nxt;
            dec_en    <= en_nxt;
            bcd_out   <= bcd_nxt;
            load_ack  <= ack_nxt;
            err       <= err_nxt;
        end
    end

    // Outputs are registered from next-state values so they line up with cnt/digit_idx.
    always_comb begin
        state_nxt   = state;
        slot_end    = (cnt == CNT_MAX);
        frame_end   = slot_end && (digit_idx == IDX_MAX);
        cnt_nxt     = slot_end ? '0 : cnt + CW'(1);
        idx_nxt     = digit_idx;
        disp_nxt    = disp;
        shadow_nxt  = shadow;
        pending_nxt = pending;
        ack_nxt     = 1'b0;

        if (slot_end)
            idx_nxt = (digit_idx == IDX_MAX) ? '0 : digit_idx + IW'(1);

        case (state)
            BLANK:   if (cnt_nxt == GUARD_C) state_nxt = DRIVE;
            DRIVE:   if (slot_end) state_nxt = BLANK;
            default: state_nxt = BLANK;
        endcase

        // A load on the frame-end cycle bypasses the shadow register.
        if (frame_end) begin
            if (load) begin
                disp_nxt    = value_in;
                ack_nxt     = 1'b1;
                pending_nxt = 1'b0;
            end else if (pending) begin
                disp_nxt    = shadow;
                ack_nxt     = 1'b1;
                pending_nxt = 1'b0;
            end
        end else if (load) begin
            shadow_nxt  = value_in;
            pending_nxt = 1'b1;
        end
    end

    always_comb begin
        hi_zero = '0;
        err_nxt = 1'b0;
        hi_zero[NUM_DIGITS-1] = (disp_nxt[NUM_DIGITS-1] == 4'd0);
        for (int k = NUM_DIGITS - 2; k >= 0; k--)
            hi_zero[k] = hi_zero[k+1] && (disp_nxt[k] == 4'd0);
        for (int k = 0; k < NUM_DIGITS; k++)
            if (disp_nxt[k] > 4'd9) err_nxt = 1'b1;

        lz      = BLANK_LZ && (idx_nxt != '0) && hi_zero[idx_nxt];
        bcd_nxt = disp_nxt[idx_nxt];
        an_nxt  = '1;
        en_nxt  = 1'b0;
        if (state_nxt == DRIVE && !lz) begin
            an_nxt[idx_nxt] = 1'b0;
            en_nxt          = 1'b1;
        end
    end
endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Directed bench for seg7_scan_ctrl (4 digits, 8-cycle slots, 2-cycle guard).
module tb_seg7_scan_ctrl;
    logic        clk = 1'b0;
    logic        rst, load;
    logic [15:0] value_in;
    logic [3:0]  bcd_out, z_bcd;
    logic        dec_en, load_ack, err, z_en, z_ack, z_err;
    logic [3:0]  an, z_an;
    logic [1:0]  digit_idx, z_idx;

    int ncmp = 0, nfail = 0, cyc = 0, nack = 0, a0 = 0;

    seg7_scan_ctrl #(.NUM_DIGITS(4), .REFRESH_DIV(8), .GUARD(2), .BLANK_LZ(1'b1)) dut (
        .clk(clk), .rst(rst), .load(load), .value_in(value_in),
        .bcd_out(bcd_out), .dec_en(dec_en), .an(an), .digit_idx(digit_idx),
        .load_ack(load_ack), .err(err));

    seg7_scan_ctrl #(.NUM_DIGITS(4), .REFRESH_DIV(8), .GUARD(2), .BLANK_LZ(1'b0)) dut_nolz (
        .clk(clk), .rst(rst), .load(load), .value_in(value_in),
        .bcd_out(z_bcd), .dec_en(z_en), .an(z_an), .digit_idx(z_idx),
        .load_ack(z_ack), .err(z_err));

    always #5 clk = ~clk;
    always @(negedge clk) if (load_ack === 1'b1) nack++;

    task automatic tick;
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic goto(input int c);
        while (cyc < c) tick();
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s @cyc %0d: observed %0h expected %0h", tag, cyc, obs, exp);
        end
    endtask

    task automatic slot(input string tag, input int c, input logic [3:0] ea,
                        input logic ee, input logic [3:0] eb);
        goto(c);
        chk({tag, "_an"}, 32'(an), 32'(ea));
        chk({tag, "_en"}, 32'(dec_en), 32'(ee));
        if (ee) chk({tag, "_bcd"}, 32'(bcd_out), 32'(eb));
    endtask

    initial begin
        rst = 1'b1; load = 1'b0; value_in = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_an", 32'(an), 32'hF);
        chk("rst_en", 32'(dec_en), 0);
        chk("rst_bcd", 32'(bcd_out), 0);
        chk("rst_ack", 32'(load_ack), 0);
        chk("rst_err", 32'(err), 0);
        chk("rst_idx", 32'(digit_idx), 0);
        rst = 1'b0; cyc = 0;

        // guard blanking after release, then digit 0 (value 0) lights
        slot("g0", 0, 4'hF, 1'b0, 4'd0);
        slot("g1", 1, 4'hF, 1'b0, 4'd0);
        slot("g2", 2, 4'hE, 1'b1, 4'd0);

        // load 1234 mid-frame, applied at frame end
        goto(5); load = 1'b1; value_in = 16'h1234; tick(); load = 1'b0;
        a0 = nack;
        goto(31); chk("ack31", 32'(load_ack), 0);
        goto(32); chk("ack32", 32'(load_ack), 1);
        chk("blank32", 32'(an), 32'hF);
        goto(33); chk("ack33", 32'(load_ack), 0);
        chk("ack_once", 32'(nack - a0), 1);
        slot("d0", 34, 4'hE, 1'b1, 4'd4);
        slot("d1", 42, 4'hD, 1'b1, 4'd3);
        slot("d2", 50, 4'hB, 1'b1, 4'd2);
        slot("d3", 58, 4'h7, 1'b1, 4'd1);
        chk("idx58", 32'(digit_idx), 3);

        // leading-zero blanking; second instance shows all digits
        goto(70); load = 1'b1; value_in = 16'h0042; tick(); load = 1'b0;
        slot("lz0", 98, 4'hE, 1'b1, 4'd2);
        goto(100); load = 1'b1; value_in = 16'h0000; tick(); load = 1'b0;
        slot("lz1", 106, 4'hD, 1'b1, 4'd4);
        slot("lz2", 114, 4'hF, 1'b0, 4'd0);
        chk("nolz2_an", 32'(z_an), 32'hB);
        chk("nolz2_en", 32'(z_en), 1);
        slot("lz3", 122, 4'hF, 1'b0, 4'd0);
        slot("zero0", 130, 4'hE, 1'b1, 4'd0);
        slot("zero1", 138, 4'hF, 1'b0, 4'd0);
        chk("nolz_z1_an", 32'(z_an), 32'hD);
        chk("nolz_z1_bcd", 32'(z_bcd), 0);

        // two loads in one frame: last wins, single ack
        goto(165); load = 1'b1; value_in = 16'h1111; tick(); load = 1'b0;
        goto(170); load = 1'b1; value_in = 16'h2222; tick(); load = 1'b0;
        a0 = nack;
        goto(193); chk("dbl_ack", 32'(nack - a0), 1);
        slot("dbl0", 194, 4'hE, 1'b1, 4'd2);
        slot("dbl3", 218, 4'h7, 1'b1, 4'd2);

        // load exactly on the frame-end cycle
        goto(223); load = 1'b1; value_in = 16'h5678; tick(); load = 1'b0;
        chk("fe_ack", 32'(load_ack), 1);
        goto(225); chk("fe_ack_off", 32'(load_ack), 0);
        slot("fe0", 226, 4'hE, 1'b1, 4'd8);
        slot("fe3", 250, 4'h7, 1'b1, 4'd5);

        // reset mid-DRIVE with a pending load
        goto(252); load = 1'b1; value_in = 16'h9999; tick(); load = 1'b0;
        goto(260); chk("pre_rst_en", 32'(dec_en), 1);
        rst = 1'b1; tick();
        chk("mrst_an", 32'(an), 32'hF);
        chk("mrst_en", 32'(dec_en), 0);
        chk("mrst_bcd", 32'(bcd_out), 0);
        chk("mrst_idx", 32'(digit_idx), 0);
        chk("mrst_ack", 32'(load_ack), 0);
        rst = 1'b0; cyc = 0; a0 = nack;
        slot("mrst_d0", 34, 4'hE, 1'b1, 4'd0);
        chk("mrst_noack", 32'(nack - a0), 0);

        // out-of-range nibble passes through and raises err
        goto(40); load = 1'b1; value_in = 16'h00A0; tick(); load = 1'b0;
        goto(63); chk("err63", 32'(err), 0);
        goto(64); chk("err64", 32'(err), 1);
        chk("ack64", 32'(load_ack), 1);
        slot("hex0", 66, 4'hE, 1'b1, 4'd0);
        slot("hex1", 74, 4'hD, 1'b1, 4'd10);
        slot("hex2", 82, 4'hF, 1'b0, 4'd0);
        chk("err82", 32'(err), 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end
endmodule
